lsu_ctrl: RTL and testbench

- Load/store unit between the execute stage (ALU result and control) and the word-wide, synchronous-read data memory.
- Accepts one byte-addressed load or store request per transaction over a valid/ready handshake.
- Turns SB/SH stores into read-modify-write sequences, because the memory only supports full-word writes.
- Performs byte-lane extraction and sign or zero extension for loads, and rejects misaligned or illegal accesses without touching memory.

---
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 tb/tb_lsu_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one byte-addressed request at a time, RMW for SB/SH, lane
// extraction and extension for loads, error response for illegal/misaligned ops.
module lsu_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;   // store data, later the merged RMW word
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                legal;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DATA_W-1:0]   ext, merged;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_we;
      3'b101:  legal = ~req_we & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext = {24'h0, lane_b};
      3'b101:  ext = {16'h0, lane_h};
      default: ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q == 3'b000) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = ~legal;
        if (!legal)                             state_d = RESP;
        else if (req_we && req_funct3 == 3'b010) state_d = WR;
        else                                    state_d = RD;
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ext;
          state_d = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced to reset values while rst is high so an in-flight
  // write is never issued on the reset cycle.
  always_comb begin
    req_ready = ~rst & (state_q == IDLE);
    rsp_valid = ~rst & (state_q == RESP);
    rsp_rdata = rst ? '0 : rdata_q;
    rsp_err   = ~rst & err_q;
    mem_en    = ~rst & ((state_q == RD) || (state_q == WR));
    mem_we    = ~rst & (state_q == WR);
    mem_addr  = mem_en ? addr_q[ADDR_W-1:2] : '0;
    mem_wdata = mem_we ? wdata_q : '0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: scoreboard queue for responses, a logged view
// of memory strobes, and a behavioural synchronous-read word memory.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  lsu_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
  typedef struct {int cyc; logic we; logic [8:0] addr; logic [31:0] wdata;} mev_t;

  exp_t        sb[$];
  mev_t        memlog[$];
  mev_t        memexp[$];
  logic [31:0] mem [512];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          seen_first = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en) memlog.push_back('{cyc, mem_we, mem_addr, mem_wdata});
  end

  // Response monitor: latency on first valid cycle, data every valid cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 80'd1, 80'd0);
      end else begin
        if (!seen_first) begin
          chk("rsp_latency", 80'(cyc), 80'(sb[0].cyc));
          seen_first = 1;
        end
        chk("rsp_data_err", {47'd0, rsp_err, rsp_rdata}, {47'd0, sb[0].err, sb[0].rdata});
        chk("req_ready_busy", 80'(req_ready), 80'd0);
        if (rsp_ready) begin
          void'(sb.pop_front());
          seen_first = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [10:0] addr,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input int lat, input bit expect_rsp, output int n);
    int t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!req_ready) chk("req_ready_timeout", 80'd0, 80'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = cyc;
    if (expect_rsp) sb.push_back('{erd, eerr, cyc + lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin @(posedge clk); t++; end
    #1;
    if (sb.size() != 0) begin
      chk("rsp_timeout", 80'(sb.size()), 80'd0);
      sb.delete();
      seen_first = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_mem(input string name);
    chk({name, "_nstrobes"}, 80'(memlog.size()), 80'(memexp.size()));
    for (int i = 0; i < memexp.size() && i < memlog.size(); i++)
      chk({name, "_strobe"},
          {15'd0, memlog[i].cyc[31:0], memlog[i].we, memlog[i].addr, memlog[i].wdata},
          {15'd0, memexp[i].cyc[31:0], memexp[i].we, memexp[i].addr, memexp[i].wdata});
    memlog.delete();
    memexp.delete();
  endtask

  function automatic logic [79:0] outs();
    return {2'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[5] = 32'h8899AABB;
    mem_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 11'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 80'(req_ready), 80'd1);
    @(posedge clk); #1;

    // Loads from word 5
    issue(1'b0, 3'b000, 11'h016, 32'h0, 32'hFFFFFF99, 1'b0, 3, 1'b1, n);
    memexp.push_back('{n + 1, 1'b0, 9'd5, 32'h0});
    wait_done(); check_mem("lb");
    issue(1'b0, 3'b101, 11'h016, 32'h0, 32'h00008899, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();
    issue(1'b0, 3'b001, 11'h014, 32'h0, 32'hFFFFAABB, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();
    issue(1'b0, 3'b010, 11'h014, 32'h0, 32'h8899AABB, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();
    issue(1'b0, 3'b100, 11'h017, 32'h0, 32'h00000088, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();

    // SB read-modify-write, then read back
    issue(1'b1, 3'b000, 11'h015, 32'h000000CC, 32'h0, 1'b0, 4, 1'b1, n);
    memexp.push_back('{n + 1, 1'b0, 9'd5, 32'h0});
    memexp.push_back('{n + 3, 1'b1, 9'd5, 32'h8899CCBB});
    wait_done(); check_mem("sb");
    issue(1'b0, 3'b010, 11'h014, 32'h0, 32'h8899CCBB, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();

    // SW: single write, no read
    issue(1'b1, 3'b010, 11'h020, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, n);
    memexp.push_back('{n + 1, 1'b1, 9'd8, 32'hDEADBEEF});
    wait_done(); check_mem("sw");
    chk("sw_mem8", 80'(mem[8]), 80'h00000000DEADBEEF);

    // Errors: no memory traffic
    issue(1'b0, 3'b010, 11'h022, 32'h0, 32'h0, 1'b1, 1, 1'b1, n);
    wait_done(); check_mem("lw_misaligned");
    issue(1'b0, 3'b011, 11'h020, 32'h0, 32'h0, 1'b1, 1, 1'b1, n);
    wait_done(); check_mem("ld_illegal");
    issue(1'b1, 3'b100, 11'h020, 32'h0, 32'h0, 1'b1, 1, 1'b1, n);
    wait_done(); check_mem("st_illegal");
    issue(1'b1, 3'b001, 11'h021, 32'h5555, 32'h0, 1'b1, 1, 1'b1, n);
    wait_done(); check_mem("sh_misaligned");

    // Backpressure: response held 4 cycles
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 11'h020, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, n);
    begin
      int t = 0;
      while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
      chk("held_valid_seen", 80'(rsp_valid), 80'd1);
    end
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done(); memlog.delete();

    // Reset during the WR of an SH
    issue(1'b1, 3'b001, 11'h016, 32'h00001234, 32'h0, 1'b0, 4, 1'b0, n);
    memexp.push_back('{n + 1, 1'b0, 9'd5, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wr_outputs", outs(), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_outputs", outs(), {2'd0, 1'b1, 77'd0});
    repeat (3) @(posedge clk);
    #1;
    check_mem("sh_reset");
    chk("sh_reset_mem5", 80'(mem[5]), 80'h000000008899CCBB);
    issue(1'b0, 3'b010, 11'h014, 32'h0, 32'h8899CCBB, 1'b0, 3, 1'b1, n);
    wait_done(); memlog.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
